// File: rtl/apb3_turret_pwm.sv
// APB3 completer driving double-buffered pan/tilt servo PWM and a timed fire pulse.
// Define TURRET_PWM_SLEW_EN to map the SLEW register and rate-limit shadow duty reloads.
module apb3_turret_pwm #(
  parameter int unsigned PRESCALE   = 100,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PERIOD_RST = 20000,
  parameter int unsigned DUTY_RST   = 1500,
  parameter int unsigned FIRE_TICKS = 50000
) (
  input  logic        pclk_i,
  input  logic        presern_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [7:0]  paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        pwm_pan_o,
  output logic        pwm_tilt_o,
  output logic        fire_o,
  output logic        period_irq_o
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);
  localparam logic [31:0] Version = 32'h0001_0373;

  typedef enum logic {StIdle, StRun} pwm_st_e;
  typedef enum logic {StFIdle, StFActive} fire_st_e;

  pwm_st_e           state_q, state_d;
  fire_st_e          fstate_q, fstate_d;
  logic              en_q, en_d, flag_q, flag_d;
  logic [CNT_W-1:0]  period_q, period_d, duty0_q, duty0_d, duty1_q, duty1_d;
  logic [CNT_W-1:0]  shadow0_q, shadow0_d, shadow1_q, shadow1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, fcnt_q, fcnt_d;
  logic [PreW-1:0]   pre_q, pre_d, fpre_q, fpre_d;
  logic [31:0]       prdata_q, prdata_d, rdata_c;
  logic              pslverr_q, pslverr_d;
  logic [CNT_W-1:0]  shadow0_nxt, shadow1_nxt, period_eff;
  logic [2:0]        idx;
  logic              mapped, err_c, wr_en, fire_req, flag_clr, tick, ftick, wrap, boundary;
  logic              unused_bits;

  assign idx         = paddr_i[4:2];
  assign unused_bits = ^{paddr_i[7:5], pwdata_i};

`ifdef TURRET_PWM_SLEW_EN
  logic [CNT_W-1:0] slew_q, slew_d;

  // Move toward the target by at most lim; lim of zero loads the target outright.
  function automatic logic [CNT_W-1:0] slew_step(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt,
                                                 input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] res;
    res = tgt;
    if (lim != '0) begin
      if (tgt > cur && (tgt - cur) > lim) res = cur + lim;
      else if (cur > tgt && (cur - tgt) > lim) res = cur - lim;
    end
    return res;
  endfunction

  assign mapped      = (idx <= 3'd6);
  assign shadow0_nxt = slew_step(shadow0_q, duty0_q, slew_q);
  assign shadow1_nxt = slew_step(shadow1_q, duty1_q, slew_q);
`else
  assign mapped      = (idx <= 3'd5);
  assign shadow0_nxt = duty0_q;
  assign shadow1_nxt = duty1_q;
`endif

  // Address and direction are stable across setup and access, so one decode serves both.
  assign err_c = psel_i & (~mapped | (pwrite_i & ((idx == 3'd5) | (paddr_i[1:0] != 2'b00))));
  assign wr_en = psel_i & penable_i & pwrite_i & ~err_c;

  assign period_eff = (period_q < CNT_W'(2)) ? CNT_W'(1) : period_q;
  assign tick       = en_q & (pre_q == PreMax);
  assign wrap       = cnt_q >= (period_eff - CNT_W'(1));
  assign ftick      = (fstate_q == StFActive) & (fpre_q == PreMax);

  always_comb begin
    en_d     = en_q;
    period_d = period_q;
    duty0_d  = duty0_q;
    duty1_d  = duty1_q;
    fire_req = 1'b0;
    flag_clr = 1'b0;
`ifdef TURRET_PWM_SLEW_EN
    slew_d   = slew_q;
`endif
    if (wr_en) begin
      case (idx)
        3'd0: begin
          en_d     = pwdata_i[0];
          fire_req = pwdata_i[1];
        end
        3'd1: period_d = pwdata_i[CNT_W-1:0];
        3'd2: duty0_d  = pwdata_i[CNT_W-1:0];
        3'd3: duty1_d  = pwdata_i[CNT_W-1:0];
        3'd4: flag_clr = pwdata_i[1];
`ifdef TURRET_PWM_SLEW_EN
        3'd6: slew_d   = pwdata_i[CNT_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow0_d = shadow0_q;
    shadow1_d = shadow1_q;
    boundary  = 1'b0;
    pre_d     = (~en_q | tick) ? '0 : pre_q + PreW'(1);
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en_d) begin
          state_d   = StRun;
          shadow0_d = duty0_q;
          shadow1_d = duty1_q;
        end
      end
      StRun: begin
        if (tick) begin
          if (wrap) begin
            cnt_d     = '0;
            shadow0_d = shadow0_nxt;
            shadow1_d = shadow1_nxt;
            boundary  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (!en_d) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    flag_d = boundary | (flag_q & ~flag_clr);
  end

  always_comb begin
    fstate_d = fstate_q;
    fpre_d   = fpre_q;
    fcnt_d   = fcnt_q;
    unique case (fstate_q)
      StFIdle: begin
        if (fire_req) begin
          fstate_d = StFActive;
          fpre_d   = '0;
          fcnt_d   = CNT_W'(FIRE_TICKS);
        end
      end
      StFActive: begin
        fpre_d = ftick ? '0 : fpre_q + PreW'(1);
        if (ftick) begin
          fcnt_d = fcnt_q - CNT_W'(1);
          if (fcnt_q <= CNT_W'(1)) fstate_d = StFIdle;
        end
      end
      default: fstate_d = StFIdle;
    endcase
  end

  always_comb begin
    rdata_c = '0;
    case (idx)
      3'd0: rdata_c = {31'b0, en_q};
      3'd1: rdata_c = 32'(period_q);
      3'd2: rdata_c = 32'(duty0_q);
      3'd3: rdata_c = 32'(duty1_q);
      3'd4: rdata_c = {30'b0, flag_q, fstate_q == StFActive};
      3'd5: rdata_c = Version;
`ifdef TURRET_PWM_SLEW_EN
      3'd6: rdata_c = 32'(slew_q);
`endif
      default: rdata_c = '0;
    endcase
    prdata_d  = (psel_i & ~penable_i & ~pwrite_i) ? rdata_c : prdata_q;
    pslverr_d = psel_i & ~penable_i & err_c;
  end

  always_ff @(posedge pclk_i or negedge presern_i) begin
    if (!presern_i) begin
      state_q   <= StIdle;
      fstate_q  <= StFIdle;
      en_q      <= 1'b0;
      flag_q    <= 1'b0;
      period_q  <= CNT_W'(PERIOD_RST);
      duty0_q   <= CNT_W'(DUTY_RST);
      duty1_q   <= CNT_W'(DUTY_RST);
      shadow0_q <= CNT_W'(DUTY_RST);
      shadow1_q <= CNT_W'(DUTY_RST);
      cnt_q     <= '0;
      fcnt_q    <= '0;
      pre_q     <= '0;
      fpre_q    <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
`ifdef TURRET_PWM_SLEW_EN
      slew_q    <= CNT_W'(10);
`endif
    end else begin
      state_q   <= state_d;
      fstate_q  <= fstate_d;
      en_q      <= en_d;
      flag_q    <= flag_d;
      period_q  <= period_d;
      duty0_q   <= duty0_d;
      duty1_q   <= duty1_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      pre_q     <= pre_d;
      fpre_q    <= fpre_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
`ifdef TURRET_PWM_SLEW_EN
      slew_q    <= slew_d;
`endif
    end
  end

  assign prdata_o     = prdata_q;
  assign pready_o     = 1'b1;
  assign pslverr_o    = pslverr_q;
  assign pwm_pan_o    = en_q & (cnt_q < shadow0_q);
  assign pwm_tilt_o   = en_q & (cnt_q < shadow1_q);
  assign fire_o       = (fstate_q == StFActive);
  assign period_irq_o = flag_q;

endmodule
